// File: rtl/var_delay_line_pkg.sv
// -----------------------------------------------------------------------------
// var_delay_line_pkg
// Shared constants and helpers for the programmable sample delay line.
//   DATA_W    : default sample width (two's complement)
//   DELAY_MAX : default number of buffer entries (power of two, >= 2)
//   clog2()   : ceiling log2, used to size the depth input, pointers and
//               the fill counter
// -----------------------------------------------------------------------------
package var_delay_line_pkg;

    localparam int DATA_W    = 11;
    localparam int DELAY_MAX = 16;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/var_delay_line_circ_buf_ram.sv
// -----------------------------------------------------------------------------
// var_delay_line_circ_buf_ram
// Circular sample store for var_delay_line: DEPTH x W, one synchronous write
// port and one asynchronous read port, so it maps onto distributed RAM.
// Contents are deliberately not reset.
//   clk   : rising-edge clock for the write port
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data, reflects the contents before a same-cycle write
// -----------------------------------------------------------------------------
module var_delay_line_circ_buf_ram #(
    parameter int W      = 11,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read: when raddr == waddr the old entry is returned, which
    // is exactly the full-depth (d = DEPTH) case of the delay line.
    assign rdata = mem[raddr];

endmodule

// File: rtl/var_delay_line.sv
// -----------------------------------------------------------------------------
// var_delay_line
// Programmable-depth delay for a signed sample stream. Each accepted sample
// (i_valid=1) is written into a circular buffer; the sample accepted d samples
// earlier is registered onto odata, with d = min(depth, MAX_DEPTH). The delay
// counts accepted samples, not clock cycles. depth=0 degenerates to a plain
// single-stage register.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (clears output, pointer, fill)
//   i_valid : idata carries a new sample this cycle
//   idata   : signed input sample, N bits
//   depth   : requested delay in samples, sampled every cycle, saturates
//   odata   : delayed sample, registered, holds between strobes
//   o_valid : one-cycle strobe marking a valid delayed sample on odata
// -----------------------------------------------------------------------------
module var_delay_line
    import var_delay_line_pkg::*;
#(
    parameter int N         = DATA_W,
    parameter int MAX_DEPTH = DELAY_MAX,
    parameter int D_W       = clog2(DELAY_MAX + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_valid,
    input  logic [N-1:0]   idata,
    input  logic [D_W-1:0] depth,
    output logic [N-1:0]   odata,
    output logic           o_valid
);

    // Pointer wraps naturally at MAX_DEPTH; the fill counter must reach
    // MAX_DEPTH itself, hence one extra bit.
    localparam int PTR_W = clog2(MAX_DEPTH);
    localparam int CNT_W = clog2(MAX_DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] fill_reg;
    logic [N-1:0]     odata_reg;
    logic             o_valid_reg;

    logic [CNT_W-1:0] eff_depth;
    logic [PTR_W-1:0] rd_addr;
    logic [N-1:0]     rd_data;
    logic             history_ok;
    logic             fill_full;

    // Saturate rather than wrap: an oversized request means "as deep as
    // the buffer allows".
    always_comb begin
        eff_depth = CNT_W'(MAX_DEPTH);
        if (depth <= D_W'(MAX_DEPTH)) begin
            eff_depth = CNT_W'(depth);
        end
    end

    // For d = MAX_DEPTH the low pointer bits of d are zero, so the read hits
    // the slot about to be overwritten -- the oldest stored sample.
    assign rd_addr    = wr_ptr_reg - eff_depth[PTR_W-1:0];
    assign history_ok = (fill_reg >= eff_depth);
    assign fill_full  = (fill_reg == CNT_W'(MAX_DEPTH));

    var_delay_line_circ_buf_ram #(
        .W      (N),
        .DEPTH  (MAX_DEPTH),
        .ADDR_W (PTR_W)
    ) u_circ_buf_ram (
        .clk   (clk),
        .we    (i_valid),
        .waddr (wr_ptr_reg),
        .wdata (idata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            fill_reg    <= '0;
            odata_reg   <= '0;
            o_valid_reg <= 1'b0;
        end else begin
            o_valid_reg <= 1'b0;
            if (i_valid) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (!fill_full) begin
                    fill_reg <= fill_reg + CNT_W'(1);
                end
                if (history_ok) begin
                    // d = 0 bypasses the buffer: the current sample is the
                    // "delayed" one.
                    odata_reg   <= (eff_depth == '0) ? idata : rd_data;
                    o_valid_reg <= 1'b1;
                end else begin
                    odata_reg   <= '0;
                end
            end
        end
    end

    assign odata   = odata_reg;
    assign o_valid = o_valid_reg;

endmodule

// File: tb/tb_var_delay_line.sv
// -----------------------------------------------------------------------------
// tb_var_delay_line
// Self-checking bench for var_delay_line. Stimulus computes the expected output
// of each cycle from a plain history of accepted samples and queues it; an
// independent monitor pops and compares one entry per clock.
// -----------------------------------------------------------------------------
module tb_var_delay_line;

    localparam int N  = 11;
    localparam int MD = 16;

    typedef struct {
        logic         v;
        logic [N-1:0] d;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         i_valid;
    logic [N-1:0] idata;
    logic [4:0]   depth;
    logic [N-1:0] odata;
    logic         o_valid;

    int vectors = 0;
    int errors  = 0;

    exp_t         exp_q[$];
    int           hist[$];
    logic [N-1:0] last_out;

    var_delay_line dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .idata   (idata),
        .depth   (depth),
        .odata   (odata),
        .o_valid (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: output of an accepted sample is the sample accepted
    // min(depth,MD) samples earlier, if that many exist since reset.
    task automatic apply(input logic v, input logic [N-1:0] x, input int dep);
        exp_t e;
        int   d;
        int   k;
        @(negedge clk);
        i_valid = v;
        idata   = x;
        depth   = 5'(dep);
        d = (dep > MD) ? MD : dep;
        k = hist.size();
        e.v = 1'b0;
        e.d = last_out;
        if (v) begin
            if (k >= d) begin
                e.v = 1'b1;
                e.d = (d == 0) ? x : N'(hist[k - d]);
            end else begin
                e.d = '0;
            end
            hist.push_back(int'(x));
        end
        last_out = e.d;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        hist.delete();
        last_out = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_valid = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expected entry per driven cycle, checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (o_valid !== e.v || odata !== e.d) begin
                    errors++;
                    $display("FAIL out: got o_valid=%0b odata=%0d, want o_valid=%0b odata=%0d at %0t",
                             o_valid, $signed(odata), e.v, $signed(e.d), $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int cur_dep;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        idata   = '0;
        depth   = '0;
        model_reset();
        #12;
        // Reset state
        vectors++;
        if (odata !== '0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got odata=%0d o_valid=%0b, want 0 0", $signed(odata), o_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 1: depth 0 bypass
        apply(1'b1, 11'sd5, 0);
        apply(1'b1, -11'sd3, 0);
        apply(1'b0, 11'sd0, 0);

        // 2: depth 3 ramp
        do_reset();
        for (int i = 1; i <= 10; i++) apply(1'b1, N'(i), 3);

        // 3: saturating depth, wraps the write pointer
        do_reset();
        for (int i = 1; i <= 40; i++) apply(1'b1, N'(i), 20);

        // 4: gaps in i_valid, extreme values
        do_reset();
        apply(1'b1, -11'sd1024, 2);
        apply(1'b0, N'($urandom), 2);
        apply(1'b0, N'($urandom), 2);
        apply(1'b1, 11'sd1023, 2);
        apply(1'b1, 11'sd7, 2);
        apply(1'b0, N'($urandom), 2);
        apply(1'b1, 11'sd9, 2);
        apply(1'b0, N'($urandom), 2);

        // 5: depth increase mid-stream
        do_reset();
        for (int i = 1; i <= 3; i++) apply(1'b1, N'(i), 2);
        for (int i = 4; i <= 8; i++) apply(1'b1, N'(i), 5);

        // 6: asynchronous reset mid-cycle
        do_reset();
        for (int i = 1; i <= 6; i++) apply(1'b1, N'(i * 11), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        i_valid = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (odata !== '0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got odata=%0d o_valid=%0b, want 0 0", $signed(odata), o_valid);
        end
        #2;
        rst_n = 1'b1;
        apply(1'b1, 11'sd77, 1);
        apply(1'b1, 11'sd88, 1);
        apply(1'b1, 11'sd99, 1);

        // Random traffic with occasional depth changes, including saturation
        do_reset();
        cur_dep = 4;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) cur_dep = $urandom_range(0, 31);
            apply($urandom_range(0, 3) != 0, N'($urandom), cur_dep);
        end

        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/var_delay_line.md
Name: var_delay_line

Overview:
- Programmable-depth sample delay for the arithmetic datapath.
- Holds back a signed N-bit stream by 0..MAX_DEPTH accepted samples.
- Used to re-align operands before combining them, e.g. matching a direct path against a pipelined multiply/add path.
- Samples advance only on i_valid, so the delay is counted in accepted samples, not clock cycles.
- The existing single-stage register is the depth=0 case of this block.

Parameters:
- N, 11, sample width (two's complement).
- MAX_DEPTH, 16, buffer entries; must be a power of 2, at least 2.
- D_W, 5, width of the depth input; must hold MAX_DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  idata is a new sample this cycle.
- idata  input  N  signed input sample.
- depth  input  D_W  requested delay in samples, sampled every cycle.
- odata  output  N  signed delayed sample, registered.
- o_valid  output  1  one-cycle strobe: odata is a valid delayed sample.

Behaviour:
- Reset (rst_n low, asynchronous):
  - odata=0, o_valid=0, wr_ptr=0, fill=0.
  - Buffer contents are not reset; o_valid gating makes stale contents unobservable.
  - Reset mid-stream discards all history; the first post-reset sample behaves as sample 0.
- Effective depth: d = min(depth, MAX_DEPTH). Out-of-range depth saturates, it never wraps.
- Accepted sample x_k (i_valid=1, k counted from reset):
  - Read address ra = (wr_ptr - d) mod MAX_DEPTH. Read is combinational and happens before the write in the same cycle.
  - d=0: the read is bypassed; the output is idata itself.
  - d=MAX_DEPTH: ra equals wr_ptr, so the old entry is read before it is overwritten.
  - mem[wr_ptr] <= idata; wr_ptr <= wr_ptr+1 (natural wrap).
  - fill <= min(fill+1, MAX_DEPTH). fill is the number of samples stored before the current one.
  - If fill >= d: odata <= x_{k-d}, o_valid <= 1.
  - Otherwise: odata <= 0, o_valid <= 0.
- Latency: one clock from the accepting edge to odata/o_valid. d=0 gives odata = idata one cycle later, with o_valid=1 from the first sample.
- i_valid=0: no write, no pointer or fill change; odata holds its value; o_valid <= 0.
- Depth change mid-stream:
  - Takes effect on the next accepted sample; fill is unchanged.
  - Increasing d above fill suppresses o_valid until fill catches up.
  - Decreasing d is valid immediately.
- Arithmetic: data is passed bit-exact with no sign handling or rounding. Pointer arithmetic is modulo MAX_DEPTH.

Decomposition:
- Shared package holds:
  - DATA_W default (11).
  - DELAY_MAX default (16).
  - A clog2-based function for D_W and pointer widths.
- One natural sub-module: circ_buf_ram.
  - MAX_DEPTH x N.
  - One synchronous write port, one asynchronous read port.
  - No reset.
  - Infers distributed RAM.
- Pointer/fill control and the output register stay in var_delay_line.

Test Plan:
1. depth=0, i_valid=1, idata=5 then -3 -> odata 5 then -3 on the following cycles; o_valid=1 from the first output.
2. depth=3, continuous ramp 1..10 -> o_valid=0 for samples 1..3. For samples 4..10, o_valid=1 and odata = 1..7, each one cycle after acceptance.
3. depth=20 (saturates to 16), ramp 1..40 -> first valid output at sample 17 with odata=1. Values then follow ramp-16, checking wrap of wr_ptr.
4. depth=2, i_valid pattern 1,0,0,1,1,0,1 with idata -1024,x,x,1023,7,x,9:
   - outputs only on valid cycles;
   - valid outputs are -1024 (with input 7) and 1023 (with input 9);
   - odata holds between strobes.
5. depth=2 for ramp samples 1..3, then depth=5 -> o_valid=0 for samples 4,5. Sample 6 gives odata=1, o_valid=1.
6. depth=1, after 6 samples assert rst_n=0 asynchronously mid-cycle -> odata=0 and o_valid=0 immediately. After release, the first sample gives o_valid=0 and the second gives odata = first post-reset value.
